// File: rtl/seq_decoder_if.sv
// Handshake/decode bundle for seq_decoder: select input side and one-hot output side.
interface seq_decoder_if #(
   parameter int IN_W = 2
) ();
   localparam int OUT_W = 2 ** IN_W;

   logic             en;
   logic             mode;
   logic             in_valid;
   logic [IN_W-1:0]  in;
   logic             in_ready;
   logic [OUT_W-1:0] out;
   logic             out_valid;
   logic [IN_W-1:0]  idx;
   logic             wrap;

   modport slave (
      input  en, mode, in_valid, in,
      output in_ready, out, out_valid, idx, wrap
   );

   modport master (
      output en, mode, in_valid, in,
      input  in_ready, out, out_valid, idx, wrap
   );
endinterface

// File: rtl/seq_decoder.sv
// Registered one-hot decoder: DIRECT decodes accepted selects, SCAN sweeps all
// outputs with a programmable dwell per step.
module seq_decoder #(
   parameter int IN_W  = 2,
   parameter int DWELL = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_decoder_if.slave bus
);
   localparam int OUT_W = 2 ** IN_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [IN_W-1:0] IDX_MAX = '1;

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

   state_e           state_q;
   logic [OUT_W-1:0] out_q;
   logic             out_valid_q;
   logic [IN_W-1:0]  idx_q;
   logic             wrap_q;
   logic [CNT_W-1:0] dwell_q;

   logic             accept;
   logic [IN_W-1:0]  idx_d;
   logic [IN_W-1:0]  idx_inc;
   logic             dwell_done;

   function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] sel);
      return OUT_W'(1) << sel;
   endfunction

   assign bus.in_ready  = (state_q == DIRECT) && bus.en;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.idx       = idx_q;
   assign bus.wrap      = wrap_q;

   assign accept     = bus.in_ready && bus.in_valid;
   // A select accepted on the same edge as a switch to SCAN becomes the scan start.
   assign idx_d      = accept ? bus.in : idx_q;
   assign idx_inc    = idx_q + IN_W'(1);
   assign dwell_done = (dwell_q == CNT_W'(DWELL - 1));

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order in this block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         wrap_q      <= 1'b0;
         dwell_q     <= '0;
      end else begin
         wrap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.en) begin
                  if (bus.mode) begin
                     state_q     <= SCAN;
                     dwell_q     <= '0;
                     out_q       <= onehot(idx_q);
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= DIRECT;
                  end
               end
            end
            DIRECT: begin
               if (!bus.en) begin
                  state_q     <= IDLE;
                  out_q       <= '0;
                  out_valid_q <= 1'b0;
               end else begin
                  if (accept || bus.mode) begin
                     idx_q       <= idx_d;
                     out_q       <= onehot(idx_d);
                     out_valid_q <= 1'b1;
                  end
                  if (bus.mode) begin
                     state_q <= SCAN;
                     dwell_q <= '0;
                  end
               end
            end
            SCAN: begin
               if (!bus.en) begin
                  state_q     <= IDLE;
                  out_q       <= '0;
                  out_valid_q <= 1'b0;
                  dwell_q     <= '0;
               end else if (!bus.mode) begin
                  state_q <= DIRECT;
                  dwell_q <= '0;
               end else if (dwell_done) begin
                  dwell_q <= '0;
                  idx_q   <= idx_inc;
                  out_q   <= onehot(idx_inc);
                  wrap_q  <= (idx_q == IDX_MAX);
               end else begin
                  dwell_q <= dwell_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: directed scenarios plus randomized traffic
// against a time-based reference model, and parameter-corner instances.
module tb_seq_decoder;
   localparam int DWELL = 4;
   localparam int OUT_W = 4;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_decoder_if #(.IN_W(2)) if0 ();
   seq_decoder_if #(.IN_W(1)) if1 ();
   seq_decoder_if #(.IN_W(6)) if6 ();

   seq_decoder #(.IN_W(2), .DWELL(DWELL)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(if0));
   seq_decoder #(.IN_W(1), .DWELL(1))     u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   seq_decoder #(.IN_W(6), .DWELL(4))     u_dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: scan position is derived from elapsed edges since scan entry.
   typedef enum int {M_OFF, M_DIRECT, M_SCAN} mstate_t;
   mstate_t m_st;
   int      m_idx, m_idx0, m_e0, m_edge;
   bit      m_valid, m_wrap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = M_OFF; m_idx = 0; m_idx0 = 0; m_e0 = 0; m_edge = 0;
      m_valid = 0; m_wrap = 0;
   endtask

   task automatic model_enter_scan();
      m_st    = M_SCAN;
      m_e0    = m_edge;
      m_idx0  = m_idx;
      m_valid = 1;
   endtask

   task automatic model_edge();
      int elapsed;
      m_edge++;
      m_wrap = 0;
      case (m_st)
         M_OFF: begin
            if (if0.en) begin
               if (if0.mode) model_enter_scan();
               else m_st = M_DIRECT;
            end
         end
         M_DIRECT: begin
            if (!if0.en) begin
               m_st = M_OFF; m_valid = 0;
            end else begin
               if (if0.in_valid) begin
                  m_idx = int'(if0.in); m_valid = 1;
               end
               if (if0.mode) model_enter_scan();
            end
         end
         M_SCAN: begin
            if (!if0.en) begin
               m_st = M_OFF; m_valid = 0;
            end else if (!if0.mode) begin
               m_st = M_DIRECT;
            end else begin
               elapsed = m_edge - m_e0;
               m_idx   = (m_idx0 + elapsed / DWELL) % OUT_W;
               m_wrap  = (elapsed % DWELL == 0) && (m_idx == 0);
            end
         end
         default: m_st = M_OFF;
      endcase
   endtask

   function automatic logic [63:0] exp_out();
      return m_valid ? (64'd1 << m_idx) : 64'd0;
   endfunction

   task automatic drive(input logic en, input logic mode, input logic iv, input logic [1:0] sel);
      if0.en = en; if0.mode = mode; if0.in_valid = iv; if0.in = sel;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("out",       if0.out,       exp_out());
      check("out_valid", 64'(if0.out_valid), 64'(m_valid));
      check("idx",       64'(if0.idx),  64'(m_idx));
      check("wrap",      64'(if0.wrap), 64'(m_wrap));
      check("in_ready",  64'(if0.in_ready), 64'((m_st == M_DIRECT) && if0.en));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int wraps;
      if0.en = 0; if0.mode = 0; if0.in_valid = 0; if0.in = '0;
      if1.en = 0; if1.mode = 0; if1.in_valid = 0; if1.in = '0;
      if6.en = 0; if6.mode = 0; if6.in_valid = 0; if6.in = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out",       if0.out,       64'd0);
      check("rst_out_valid", 64'(if0.out_valid), 64'd0);
      check("rst_idx",       64'(if0.idx),  64'd0);
      check("rst_wrap",      64'(if0.wrap), 64'd0);
      check("rst_in_ready",  64'(if0.in_ready), 64'd0);
      #1 rst_n = 1'b1;

      // Direct sweep
      drive(1, 0, 0, 0);
      cycle();
      for (int v = 0; v < 4; v++) begin
         drive(1, 0, 1, 2'(v));
         cycle();
         check("sweep_out", if0.out, 64'd1 << v);
         check("sweep_valid", 64'(if0.out_valid), 64'd1);
      end
      drive(1, 0, 0, 0);
      cycle();
      check("direct_hold", if0.out, 64'h8);

      // Mode switch from idx=2
      drive(1, 0, 1, 2);
      cycle();
      drive(1, 1, 0, 0);
      cycle();
      check("scan_start", if0.out, 64'h4);
      repeat (4) cycle();
      check("scan_step", if0.out, 64'h8);
      repeat (2) cycle();
      drive(1, 0, 0, 0);
      cycle();
      check("switch_hold", if0.out, 64'h8);
      check("switch_ready", 64'(if0.in_ready), 64'd1);

      // Scan wrap from reset
      drive(0, 0, 0, 0);
      do_reset();
      drive(1, 1, 0, 0);
      wraps = 0;
      for (int k = 0; k < 18; k++) begin
         cycle();
         if (if0.wrap) wraps++;
      end
      check("wrap_count", 64'(wraps), 64'd1);

      // Enable drop during scan, then resume
      drive(0, 1, 0, 0);
      cycle();
      check("drop_out", if0.out, 64'd0);
      check("drop_ready", 64'(if0.in_ready), 64'd0);
      drive(1, 1, 0, 0);
      repeat (6) cycle();

      // Async reset mid-dwell, between edges
      #2 rst_n = 1'b0;
      #1;
      check("arst_out",   if0.out, 64'd0);
      check("arst_idx",   64'(if0.idx), 64'd0);
      check("arst_valid", 64'(if0.out_valid), 64'd0);
      check("arst_wrap",  64'(if0.wrap), 64'd0);
      model_reset();
      #1 rst_n = 1'b1;

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic en, mode;
         en   = ($urandom_range(0, 9) != 0);
         mode = ($urandom_range(0, 7) == 0) ? ~if0.mode : if0.mode;
         drive(en, mode, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         cycle();
      end
      drive(0, 0, 0, 0);

      // IN_W=1, DWELL=1: alternate every cycle, wrap every second cycle
      if1.en = 1; if1.mode = 1;
      @(posedge clk); #1;
      check("c1_entry", 64'(if1.out), 64'd1);
      for (int k = 1; k < 7; k++) begin
         @(posedge clk); #1;
         check("c1_out",  64'(if1.out),  64'd1 << (k % 2));
         check("c1_wrap", 64'(if1.wrap), 64'((k % 2) == 0));
      end
      if1.en = 0;

      // IN_W=6 direct decode of the top select
      if6.en = 1; if6.mode = 0;
      @(posedge clk); #1;
      if6.in_valid = 1; if6.in = 6'd63;
      @(posedge clk); #1;
      if6.in_valid = 0;
      check("c6_out",   if6.out, 64'h8000_0000_0000_0000);
      check("c6_idx",   64'(if6.idx), 64'd63);
      check("c6_valid", 64'(if6.out_valid), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL have parameter IN_W, default 2, select width (legal range 1..6).
REQ-002 The block SHALL have parameter DWELL, default 4, clock cycles per scan step (legal range 1..256).
REQ-003 The block SHALL derive localparam OUT_W = 2**IN_W, the one-hot output width.
REQ-004 Port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port en, input, 1 bit: block enable.
REQ-007 Port mode, input, 1 bit: 0 = DIRECT (decode accepted input), 1 = SCAN (auto-sweep outputs).
REQ-008 Port in_valid, input, 1 bit: the in field is valid.
REQ-009 Port in, input, IN_W bits: select value to decode.
REQ-010 Port in_ready, output, 1 bit: block accepts in this cycle.
REQ-011 Port out, output, OUT_W bits: registered one-hot decode.
REQ-012 Port out_valid, output, 1 bit: out holds a valid decode.
REQ-013 Port idx, output, IN_W bits: index currently driven one-hot on out.
REQ-014 Port wrap, output, 1 bit: single-cycle pulse when the scan wraps from OUT_W-1 to 0.

Function
REQ-015 The block SHALL implement FSM states IDLE, DIRECT and SCAN.
REQ-016 IDLE: out=0, out_valid=0, in_ready=0, wrap=0; idx SHALL hold its last value.
REQ-017 In IDLE with en=1, the FSM SHALL move to DIRECT if mode=0 and to SCAN if mode=1, on the next edge.
REQ-018 In DIRECT or SCAN, en=0 SHALL return the FSM to IDLE on the next edge; out and out_valid SHALL be 0 from that edge.
REQ-019 in_ready SHALL be combinationally 1 only when state=DIRECT and en=1.
REQ-020 DIRECT: on in_valid && in_ready, the next edge SHALL set idx=in, out=1<<in, out_valid=1 (latency 1 cycle).
REQ-021 DIRECT: without a handshake, out, idx and out_valid SHALL hold; out_valid SHALL stay 1 after the first accept until the block leaves DIRECT.
REQ-022 Entering SCAN SHALL clear the dwell counter and set out=1<<idx, out_valid=1, so the sweep resumes from the current idx.
REQ-023 SCAN: the dwell counter SHALL count 0..DWELL-1. At DWELL-1 it SHALL return to 0 and idx SHALL increment by one modulo OUT_W, with out tracking idx on the same edge.
REQ-024 SCAN: when idx steps from OUT_W-1 to 0, wrap SHALL be 1 for exactly the cycle after that edge.
REQ-025 DWELL=1 SHALL step idx every cycle. IN_W=1 SHALL alternate out between 01 and 10.
REQ-026 A mode change while en=1 SHALL switch DIRECT<->SCAN on the next edge.
REQ-027 Leaving SCAN for DIRECT SHALL keep out/idx/out_valid as they were at the switch, and SHALL discard the dwell count.
REQ-028 in_valid is ignored whenever in_ready=0; no input SHALL be queued.
REQ-029 out SHALL always be zero or exactly one-hot; out SHALL never be nonzero while out_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately and asynchronously force: state=IDLE, out=0, out_valid=0, idx=0, wrap=0, dwell counter=0. in_ready=0 follows from state=IDLE.
REQ-031 Reset asserted mid-scan or mid-handshake SHALL abandon the operation with no partial update after release.
REQ-032 After rst_n deasserts, the first state change SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-033 Direct sweep: IN_W=2, en=1, mode=0, apply in=0,1,2,3 each with in_valid=1 for one cycle -> out=0001,0010,0100,1000 one cycle after each accept, out_valid=1 throughout.
REQ-034 Scan wrap: IN_W=2, DWELL=4, en=1, mode=1 from reset -> idx steps 0,1,2,3,0 every 4 cycles; wrap pulses for exactly one cycle when idx returns to 0.
REQ-035 Mode switch: in DIRECT with idx=2, set mode=1 -> scan starts at out=0100 and reaches 1000 after 4 cycles. Set mode=0 mid-dwell -> out holds and in_ready=1.
REQ-036 Enable drop: en=0 during SCAN -> next edge out=0, out_valid=0, in_ready=0, idx held. Re-enable in SCAN -> resumes from the held idx.
REQ-037 Async reset: assert rst_n=0 mid-dwell between edges -> out=0, idx=0, out_valid=0 before the next clock edge.
REQ-038 Parameter corners: IN_W=1 with DWELL=1 -> out alternates 01/10 each cycle with wrap every 2 cycles. IN_W=6 direct in=63 -> out bit 63 only.
